// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory arbiter.
//   owner_e            : read-data owner tag (none / CPU / host)
//   STARVE_MAX_DEFAULT : default number of consecutive contended CPU wins
//                        before the host is forced in
//   STARVE_W           : width of the starvation counter
package cpu_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int STARVE_W           = 4;

endpackage

// File: rtl/reg_arstn_en.sv
// Generic register with asynchronous active-low reset and load enable.
//   clk    : clock
//   arst_n : asynchronous reset, active low, loads RST_VAL
//   en     : load enable
//   d      : next value
//   q      : registered value
module reg_arstn_en #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage, the external
// host port and the data SRAM.
//   clk, arst_n                          : clock, async active-low reset
//   cpu_req/wen/addr/wdata               : CPU access request and payload
//   cpu_stall                            : CPU request pending, not granted
//   cpu_rdata/cpu_rvalid                 : CPU read response (1 cycle after grant)
//   ext_req/wen/addr/wdata               : host access request and payload
//   ext_gnt                              : host request accepted this cycle
//   ext_rdata/ext_rvalid                 : host read response
//   mem_addr/wen/ren/wdata, mem_rdata    : SRAM port (1-cycle read latency)
// The CPU normally wins contention; after STARVE_MAX consecutive contended
// CPU wins the host is forced in, bounding host wait to STARVE_MAX+1 cycles.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_next;
  logic [1:0]          rd_owner_q;
  owner_e              rd_owner;
  owner_e              rd_owner_next;
  logic                host_forced;
  logic                cpu_granted;
  logic                ext_granted;

  // Grant decision.
  always_comb begin
    host_forced = ext_req && (starve_cnt == STARVE_LIM);
    cpu_granted = cpu_req && !host_forced;
    ext_granted = ext_req && !cpu_granted;
  end

  assign cpu_stall = cpu_req && !cpu_granted;
  assign ext_gnt   = ext_granted;

  // SRAM drive from the winner's payload; idle bus is all zero.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (cpu_granted) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
      mem_ren   = !cpu_wen;
    end else if (ext_granted) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_wen;
      mem_ren   = !ext_wen;
    end
  end

  // Counts contended CPU wins only; any cycle the host is not waiting, or is
  // served, restarts the count. The saturation guard is defensive: at the
  // limit the host is forced, so the CPU cannot win a contended cycle there.
  always_comb begin
    starve_next = '0;
    if (ext_req && cpu_granted) begin
      starve_next = (starve_cnt == STARVE_LIM) ? starve_cnt
                                               : starve_cnt + STARVE_W'(1);
    end
  end

  // Tag of the read issued this cycle, consumed next cycle to steer mem_rdata.
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (cpu_granted && !cpu_wen) begin
      rd_owner_next = OWN_CPU;
    end else if (ext_granted && !ext_wen) begin
      rd_owner_next = OWN_EXT;
    end
  end

  reg_arstn_en #(
    .W       (STARVE_W),
    .RST_VAL ('0)
  ) u_starve_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (1'b1),
    .d      (starve_next),
    .q      (starve_cnt)
  );

  reg_arstn_en #(
    .W       (2),
    .RST_VAL (OWN_NONE)
  ) u_rd_owner (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (1'b1),
    .d      (rd_owner_next),
    .q      (rd_owner_q)
  );

  assign rd_owner = owner_e'(rd_owner_q);

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign ext_rvalid = (rd_owner == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised plus directed bench for dmem_arbiter with a scoreboard of
// expected read responses and a behavioural model of the arbitration policy.
module tb_dmem_arbiter;
  import cpu_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_wen = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ext_req = 1'b0, ext_wen = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wen, mem_ren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .arst_n(arst_n),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM attached to the DUT: one-cycle read latency.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= sram[mem_addr];
    if (mem_wen) sram[mem_addr] = mem_wdata;
  end

  // Reference model state.
  typedef struct {
    int            due;
    int            own;   // 1 = CPU, 2 = host
    logic [DW-1:0] data;
  } resp_t;

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  resp_t         exp_q[$];
  int            cpu_streak = 0;   // consecutive CPU wins while host waited
  int            host_wait = 0;    // cycles host has been requesting
  int            cyc = 0;
  int            n_pass = 0;
  int            n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int a);
    return (a == 5) ? 32'hDEADBEEF : (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  // Response monitor: pops the scoreboard whenever a response is due.
  always @(negedge clk) begin
    resp_t e;
    logic [127:0] want;
    want = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (e.own == 1) want = {62'd0, 1'b1, 1'b0, e.data, 32'd0};
      else            want = {62'd0, 1'b0, 1'b1, 32'd0, e.data};
      $display("resp cyc=%0d owner=%0d data=%h", cyc, e.own, e.data);
    end
    check("rdata", {62'd0, cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata}, want);
  end

  // One cycle: drive at posedge+1, model and check at negedge.
  task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      output logic c_acc, output logic e_acc);
    logic cpu_wins, ext_wins, w, r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [127:0] want;
    cpu_req = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_wen = ew; ext_addr = ea; ext_wdata = ed;
    @(negedge clk);
    cpu_wins = cr && !(er && cpu_streak >= SM);
    ext_wins = er && !cpu_wins;
    w = 1'b0; r = 1'b0; a = '0; d = '0;
    if (cpu_wins)      begin w = cw; r = !cw; a = ca; d = cd; end
    else if (ext_wins) begin w = ew; r = !ew; a = ea; d = ed; end
    want = {82'd0, cr && !cpu_wins, ext_wins, w, r, a, d};
    check("grant", {82'd0, cpu_stall, ext_gnt, mem_wen, mem_ren, mem_addr, mem_wdata}, want);
    $display("txn cyc=%0d cpu=%b%b@%0d ext=%b%b@%0d -> cpu_win=%b ext_win=%b",
             cyc, cr, cw, ca, er, ew, ea, cpu_wins, ext_wins);
    if (r) exp_q.push_back('{cyc + 1, cpu_wins ? 1 : 2, ref_mem[a]});
    if (w) ref_mem[a] = d;
    cpu_streak = (er && cpu_wins) ? ((cpu_streak < SM) ? cpu_streak + 1 : SM) : 0;
    // Host wait measured from DUT grants, inclusive of the grant cycle.
    if (er) begin
      host_wait++;
      if (ext_gnt) begin
        check("host_wait_bound", {127'd0, host_wait <= SM + 1}, 128'd1);
        host_wait = 0;
      end
    end else begin
      host_wait = 0;
    end
    c_acc = cpu_wins;
    e_acc = ext_wins;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_wen = 1'b0; ext_addr = '0; ext_wdata = '0;
    exp_q.delete();
    cpu_streak = 0;
    host_wait = 0;
    @(negedge clk);
    check("reset_outputs",
          {cpu_stall, ext_gnt, mem_wen, mem_ren, cpu_rvalid, ext_rvalid, mem_addr, mem_wdata, cpu_rdata, ext_rdata},
          128'd0);
    $display("txn cyc=%0d reset", cyc);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    logic ca, ea;
    logic cp_v, cp_w, ep_v, ep_w;
    logic [AW-1:0] cp_a, ep_a;
    logic [DW-1:0] cp_d, ep_d;

    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end

    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, ca, ea);                       // idle

    step(1, 0, 5, 0, 0, 0, 0, 0, ca, ea);                       // CPU read 5
    step(1, 1, 3, 32'h12, 1, 0, 7, 0, ca, ea);                  // CPU write wins
    step(0, 0, 0, 0, 1, 0, 7, 0, ca, ea);                       // host read 7
    step(0, 0, 0, 0, 0, 0, 0, 0, ca, ea);

    for (int n = 0; n < 15; n++) step(1, 0, 10, 0, 1, 0, 11, 0, ca, ea);  // saturation
    step(0, 0, 0, 0, 0, 0, 0, 0, ca, ea);

    for (int n = 0; n < 8; n++) begin                           // alternating owners
      if (n % 2 == 0) step(1, 0, 1, 0, 0, 0, 0, 0, ca, ea);
      else            step(0, 0, 0, 0, 1, 0, 2, 0, ca, ea);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, ca, ea);

    step(1, 0, 5, 0, 0, 0, 0, 0, ca, ea);                       // read then reset
    do_reset();
    step(1, 0, 6, 0, 1, 0, 9, 0, ca, ea);                       // CPU wins first
    step(0, 0, 0, 0, 1, 0, 9, 0, ca, ea);

    // Random traffic; each requester holds its payload until accepted.
    cp_v = 0; cp_w = 0; cp_a = '0; cp_d = '0;
    ep_v = 0; ep_w = 0; ep_a = '0; ep_d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!cp_v && $urandom_range(0, 9) < 7) begin
        cp_v = 1; cp_w = ($urandom_range(0, 2) == 0); cp_a = AW'($urandom_range(0, 15)); cp_d = $urandom;
      end
      if (!ep_v && $urandom_range(0, 9) < 6) begin
        ep_v = 1; ep_w = ($urandom_range(0, 2) == 0); ep_a = AW'($urandom_range(0, 15)); ep_d = $urandom;
      end
      step(cp_v, cp_w, cp_a, cp_d, ep_v, ep_w, ep_a, ep_d, ca, ea);
      if (ca) cp_v = 0;
      if (ea) ep_v = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, ca, ea);
    step(0, 0, 0, 0, 0, 0, 0, 0, ca, ea);

    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter placed between the CPU MEM stage, the external host port and the data SRAM. Grants one requester per cycle, routes the one-cycle-latency read data back to the owner via a registered tag, stalls the CPU pipeline when it loses arbitration, and guarantees the host forward progress with a starvation counter.

## Interface
- ADDR_W, 10, SRAM word-address width
- DATA_W, 32, data width
- STARVE_MAX, 4, contended cycles the CPU may win consecutively before the host is forced in (1..15)
- clk  in  1  clock
- arst_n  in  1  reset; one clock, reset is asynchronous and active-low
- cpu_req  in  1  MEM-stage access request (mem_read | mem_write)
- cpu_wen  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_stall  out  1  CPU request pending but not granted this cycle; pipeline enable held low
- cpu_rdata  out  DATA_W  read data
- cpu_rvalid  out  1  cpu_rdata valid
- ext_req, ext_wen, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  host request, same meaning
- ext_gnt  out  1  host request accepted this cycle
- ext_rdata  out  DATA_W  read data
- ext_rvalid  out  1  ext_rdata valid
- mem_addr  out  ADDR_W  to SRAM
- mem_wen, mem_ren  out  1  SRAM strobes, mutually exclusive
- mem_wdata  out  DATA_W  to SRAM
- mem_rdata  in  DATA_W  SRAM data, valid one cycle after mem_ren

## Operation
- Requesters hold req and payload stable until accepted (CPU: cpu_stall low with cpu_req high; host: ext_gnt high).
- Grant decision combinational from req and state; SRAM drive (mem_*) combinational from winner's payload; no winner -> mem_wen = mem_ren = 0, mem_addr/mem_wdata = 0.
- Policy: only one requests -> it wins. Both request -> CPU wins unless starve_cnt == STARVE_MAX, then host wins.
- starve_cnt (4 bits): +1 on each cycle CPU wins while ext_req high; cleared on host grant or when ext_req low; saturates at STARVE_MAX.
- Read tag: registered rd_owner in {NONE, CPU, EXT}, set to winner on a read grant, NONE otherwise. Next cycle: rd_owner CPU -> cpu_rvalid = 1, cpu_rdata = mem_rdata; EXT -> ext_rvalid, ext_rdata likewise. Non-owner rdata = 0.
- Writes complete in the grant cycle; no response.
- cpu_stall = cpu_req & ~cpu_granted.

## Timing
- Reset: starve_cnt = 0, rd_owner = NONE; all outputs 0 while arst_n low (given req inputs low).
- Grant latency 0 cycles; read-data latency 1 cycle after grant; throughput 1 access/cycle, back-to-back reads from alternating owners allowed (tag pipelined).
- Worst-case host wait with CPU saturating: STARVE_MAX + 1 cycles.
- Simultaneous read of owner A and grant to owner B same cycle as A's rvalid: legal, independent.
- Reset mid-read: rd_owner cleared, pending rvalid dropped.
- starve_cnt update and rd_owner capture on rising clk; no other state.

## Structure
- Shared package (cpu_pkg): owner enum OWN_NONE/OWN_CPU/OWN_EXT (2 bits), default STARVE_MAX.
- No sub-module; counter and tag register are inline, built from the existing reg_arstn_en flop.

## Test plan
- Reset then idle -> all outputs 0, rd_owner NONE.
- CPU read addr 5 alone (SRAM[5]=0xDEADBEEF) -> cpu_stall 0, mem_ren 1, next cycle cpu_rvalid 1, cpu_rdata 0xDEADBEEF, ext_rvalid 0.
- CPU write addr 3 data 0x12 and host read addr 7 same cycle -> CPU wins, ext_gnt 0; next cycle ext_gnt 1, then ext_rvalid with SRAM[7].
- CPU and host both request continuously, STARVE_MAX=4 -> 4 CPU grants, 1 host grant (cpu_stall 1 that cycle), repeat; host never waits > 5 cycles.
- Alternating reads CPU(addr 1), host(addr 2) every cycle -> rvalid alternates, each rdata matches its own address.
- arst_n low in cycle after a CPU read grant -> cpu_rvalid stays 0; after release, counter 0 and CPU wins first contention.
